// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared state type and mode constants for the stream arbiter mux
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first requester after ptr_i, searching upward with wrap
module rr_pick #(
  parameter int N_CH  = 4,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  // Walk from farthest to nearest so the nearest requester after ptr_i is the last writer.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N_CH; i >= 1; i--) begin
      if (req_i[(int'(ptr_i) + i) % N_CH]) begin
        found_o = 1'b1;
        idx_o   = SEL_W'((int'(ptr_i) + i) % N_CH);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_mux.sv
// rtl/stream_arbiter_mux.sv - N-channel packet mux with manual/round-robin arbitration and a registered output
module stream_arbiter_mux
  import stream_mux_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  N_CH  = 4,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic             man_found;
  logic             cand_found;
  logic [SEL_W-1:0] cand_idx;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req_i   (in_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  // Out-of-range sel_in never matches any k, so it naturally yields no candidate.
  always_comb begin
    man_found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_in == SEL_W'(k) && in_valid[k]) man_found = 1'b1;
    end
  end

  always_comb begin
    cand_found  = (mode == MODE_RR) ? rr_found : man_found;
    cand_idx    = (mode == MODE_RR) ? rr_idx : sel_in;
    beat_data   = in_data[int'(grant_q)*WIDTH +: WIDTH];
    beat_last   = in_last[grant_q];
    accept      = !out_valid_q || out_ready;

    in_ready    = '0;
    xfer        = 1'b0;
    if (state_q == LOCKED && !reset) begin
      in_ready[grant_q] = accept;
      xfer              = accept && in_valid[grant_q];
    end

    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cand_found) begin
          grant_d  = cand_idx;
          rr_ptr_d = cand_idx;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          out_data_d  = beat_data;
          out_last_d  = beat_last;
          out_ch_d    = grant_q;
          out_valid_d = 1'b1;
          if (beat_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rr_ptr starts at the last channel so channel 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_arbiter_mux.sv
// tb/tb_stream_arbiter_mux.sv - scoreboard bench for stream_arbiter_mux with per-channel packet producers
module tb_stream_arbiter_mux;

  localparam int WIDTH = 8;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       first;
  } beat_t;

  typedef struct {
    logic [7:0]       data;
    logic             last;
    logic [SEL_W-1:0] ch;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic                  mode;
  logic [SEL_W-1:0]      sel_in;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;

  beat_t       chq[N_CH][$];
  exp_t        exp_q[$];
  logic [N_CH-1:0] fire;
  bit          rand_ready;
  bit          gap_en;
  int          n_checks;
  int          n_pass;

  stream_arbiter_mux #(
    .WIDTH (WIDTH),
    .N_CH  (N_CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel_in    (sel_in),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_pkt(input int ch, input int len, input logic [7:0] d0,
                          input logic [7:0] step, input bit rnd);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      exp_t  e;
      b.data  = rnd ? 8'($urandom) : d0 + 8'(i) * step;
      b.last  = (i == len - 1);
      b.first = (i == 0);
      chq[ch].push_back(b);
      e.data = b.data;
      e.last = b.last;
      e.ch   = SEL_W'(ch);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < N_CH; k++) chq[k].delete();
    exp_q.delete();
    fire = '0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_all();
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_exp(input int target, input int budget, input string name);
    int c = 0;
    while (exp_q.size() > target && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk(name, exp_q.size(), target);
  endtask

  task automatic wait_out_valid(input int budget, input string name);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < budget);
    chk(name, out_valid, 1);
  endtask

  // Producers: a packet's first beat is offered at once, later beats may gap; an offered beat is held until taken.
  task automatic producer();
    forever begin
      @(posedge clk); #2;
      for (int k = 0; k < N_CH; k++) begin
        if (fire[k] && chq[k].size() > 0) void'(chq[k].pop_front());
        if (chq[k].size() == 0) in_valid[k] = 1'b0;
        else if (!(in_valid[k] && !fire[k]))
          in_valid[k] = chq[k][0].first || !gap_en || ($urandom_range(0, 3) != 0);
        if (chq[k].size() > 0) begin
          in_data[k*WIDTH +: WIDTH] = chq[k][0].data;
          in_last[k]                = chq[k][0].last;
        end
      end
      fire = '0;
      if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      if (!reset) begin
        chk("in_ready_onehot", ($countones(in_ready) <= 1), 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got data 0x%0h ch %0d, expected no beat", out_data, out_ch);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_data", out_data, e.data);
            chk("sb_last", out_last, e.last);
            chk("sb_ch", out_ch, e.ch);
          end
        end
      end
    end
  end

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1; mode = 1'b1; sel_in = '0;
    in_data = '0; in_valid = '0; in_last = '0;
    out_ready = 1'b1; rand_ready = 1'b0; gap_en = 1'b0; fire = '0;
    fork producer(); join_none

    // Reset with every channel requesting, then channel 0 wins first in round-robin.
    @(posedge clk); #1;
    clear_all();
    for (int k = 0; k < N_CH; k++) send_pkt(k, 1, 8'h10 + 8'(k), 8'h00, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("t1_rst_out_valid", out_valid, 0);
      chk("t1_rst_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t1_idle_out_valid", out_valid, 0);
    chk("t1_idle_in_ready", in_ready, 0);
    @(negedge clk);
    chk("t1_first_grant", in_ready, 4'b0001);
    wait_exp(0, 200, "t1_drain");

    // Manual 3-beat packet on ch2; sel_in moved to 1 mid-packet only matters at the next arbitration.
    @(posedge clk); #1;
    mode = 1'b0; sel_in = 2'd2;
    send_pkt(2, 3, 8'h11, 8'h11, 1'b0);
    send_pkt(1, 1, 8'h44, 8'h00, 1'b0);
    @(negedge clk);
    chk("t2_lat0_valid", out_valid, 0);
    @(negedge clk);
    chk("t2_lat1_valid", out_valid, 0);
    chk("t2_in_ready", in_ready, 4'b0100);
    @(posedge clk); #1 sel_in = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_beat_valid", out_valid, 1);
      chk("t2_beat_data", out_data, 8'h11 * (i + 1));
      chk("t2_beat_ch", out_ch, 2);
      chk("t2_beat_last", out_last, (i == 2));
    end
    wait_exp(0, 200, "t2_drain");

    // Round-robin fairness with single-beat packets: one bubble between every packet.
    do_reset(1);
    mode = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N_CH; k++) send_pkt(k, 1, 8'hA0 + 8'(k), 8'h00, 1'b0);
    wait_out_valid(10, "t3_first_valid");
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t3_bubble", out_valid, 0);
      @(negedge clk);
      chk("t3_beat", out_valid, 1);
    end
    wait_exp(0, 200, "t3_drain");

    // Backpressure: output beat must hold and the granted input must stall.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_pkt(0, 3, 8'h5C, 8'h01, 1'b0);
    wait_out_valid(10, "t4_valid");
    chk("t4_first_data", out_data, 8'h5C);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 8'h5C);
      chk("t4_hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_exp(0, 200, "t4_drain");

    // Manual select of an idle channel leaves the mux idle until sel_in points at a requester.
    @(posedge clk); #1;
    mode = 1'b0; sel_in = 2'd3;
    send_pkt(1, 1, 8'h71, 8'h00, 1'b0);
    send_pkt(0, 1, 8'h70, 8'h00, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_idle_in_ready", in_ready, 0);
      chk("t5_idle_out_valid", out_valid, 0);
    end
    @(posedge clk); #1 sel_in = 2'd1;
    @(negedge clk);
    chk("t5_pre_grant", in_ready, 0);
    @(negedge clk);
    chk("t5_grant_ch1", in_ready, 4'b0010);
    wait_exp(1, 200, "t5_ch1_done");
    @(posedge clk); #1 sel_in = 2'd0;
    wait_exp(0, 200, "t5_drain");

    // Reset mid-packet drops the packet; ch1 is regranted and restarts cleanly.
    @(posedge clk); #1;
    mode = 1'b1;
    send_pkt(1, 4, 8'h81, 8'h01, 1'b0);
    wait_exp(2, 200, "t6_two_beats");
    do_reset(1);
    @(negedge clk);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    send_pkt(1, 4, 8'hC1, 8'h01, 1'b0);
    wait_exp(0, 200, "t6_restart_drain");

    // Randomized round-robin with every channel saturated: strict 0,1,2,3 packet order.
    do_reset(1);
    mode = 1'b1; rand_ready = 1'b1; gap_en = 1'b1;
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < N_CH; k++)
        send_pkt(k, $urandom_range(1, 4), 8'h00, 8'h00, 1'b1);
    wait_exp(0, 3000, "rr_rand_drain");

    // Randomized manual phases with sel_in flicking to idle channels.
    @(posedge clk); #1;
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      int c;
      int cyc;
      c = $urandom_range(0, N_CH - 1);
      sel_in = SEL_W'(c);
      for (int p = 0; p < 3; p++) send_pkt(c, $urandom_range(1, 4), 8'h00, 8'h00, 1'b1);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 2000) begin
        @(posedge clk); #1;
        sel_in = ($urandom_range(0, 3) == 0) ? SEL_W'((c + $urandom_range(1, N_CH - 1)) % N_CH)
                                             : SEL_W'(c);
        cyc++;
      end
      chk("man_rand_drain", exp_q.size(), 0);
    end

    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_arbiter_mux.md
Name: stream_arbiter_mux

Overview:
- Parametrised N-channel, WIDTH-bit packet multiplexer with a valid/ready handshake on every port.
- Successor to the team's fixed 4:1 combinational byte mux.
- Adds runtime-selectable manual or round-robin arbitration, packet locking on a `last` flag, and a registered output stage.
- Sits between several packet producers and a single downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- N_CH, 4, number of input channels (>=1).
- SEL_W, derived localparam = max(1, $clog2(N_CH)), channel index width. Not overridable.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = manual (use sel_in), 1 = round-robin. Sampled only in IDLE.
- sel_in  in  SEL_W  manual channel select. Sampled only in IDLE.
- in_data  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  N_CH  per-channel valid.
- in_last  in  N_CH  per-channel end-of-packet flag, qualified by valid.
- in_ready  out  N_CH  per-channel ready; at most one bit high.
- out_data  out  WIDTH  registered data.
- out_last  out  1  registered last.
- out_ch  out  SEL_W  index of the channel that sourced out_data.
- out_valid  out  1  registered valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Handshake:
  - A beat transfers on any edge where valid && ready.
  - Producers must hold data/last while valid && !ready.
- Reset (synchronous, active-high):
  - state = IDLE, grant = 0, rr_ptr = N_CH-1 (so channel 0 wins first).
  - out_valid = 0, out_data = 0, out_last = 0, out_ch = 0, in_ready = 0.
  - Reset asserted mid-packet drops the packet and any held output beat; out_valid is 0 on the cycle after the reset edge.
- FSM state IDLE:
  - in_ready is all 0.
  - Candidate selection:
    - mode=0: candidate = sel_in if sel_in < N_CH and in_valid[sel_in] is high; otherwise no candidate.
    - mode=1: candidate = first k with in_valid[k] high, searching (rr_ptr+1) mod N_CH upward with wrap.
  - With a candidate: next edge latches grant = candidate, sets rr_ptr = candidate (both modes), and moves to LOCKED.
  - Without a candidate: stay in IDLE.
- FSM state LOCKED:
  - in_ready[grant] = !out_valid || out_ready. All other in_ready bits are 0.
  - On a transfer: out_data/out_last/out_ch load from channel grant and out_valid = 1.
  - If the transferred beat has in_last=1, next state = IDLE.
  - mode and sel_in changes are ignored while LOCKED.
- Output register:
  - Behaves as a one-deep pipeline.
  - If out_valid && out_ready and no new beat loads, out_valid -> 0.
  - If out_valid && !out_ready, all out_* hold stable.
  - Full throughput within a packet when out_ready is held high.
- Latency:
  - Request valid in IDLE at cycle t -> grant edge at end of t -> first beat accepted at end of t+1 -> out_valid high in cycle t+2.
  - Each packet costs one IDLE arbitration bubble. Back-to-back packets have one idle cycle between the last beat and the next grant.
- Single-beat packet (last on first beat): returns to IDLE after one transfer.
- If the granted channel drops in_valid mid-packet, stay LOCKED and wait; there is no timeout.
- N_CH=1: SEL_W=1, only channel 0 is ever selectable, and sel_in=1 means no candidate.

Decomposition:
- Shared package stream_mux_pkg holds:
  - the state enum {IDLE, LOCKED};
  - MODE_MANUAL=1'b0 and MODE_RR=1'b1 constants.
- One natural sub-module, rr_pick.
  - Combinational.
  - Parameterised on N_CH.
  - Inputs: request vector and pointer.
  - Outputs: found and index.
  - Unit-testable on its own.
- The output register and FSM stay in the top module.

Test Plan:
1. Reset then idle: assert reset 2 cycles with all in_valid=1 -> out_valid=0 and in_ready=0 during reset and on the cycle after release. First grant in mode=1 goes to channel 0.
2. Manual mode, WIDTH=8, N_CH=4, mode=0, sel_in=2, ch2 sends 3-beat packet 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after valid, out_ch=2, out_last only on 0x33. Changing sel_in to 1 mid-packet has no effect.
3. Round-robin fairness: all 4 channels continuously send 1-beat packets (data = 0xA0+k) -> out_ch sequence 0,1,2,3,0,1. Each packet separated by exactly one bubble cycle.
4. Backpressure: hold out_ready=0 for 5 cycles while a beat 0x5C is in the output register -> out_data=0x5C stable, out_valid=1, and in_ready[grant]=0 throughout. On release, the next beat follows with no loss or duplication.
5. Manual select of an idle or out-of-range channel: mode=0, sel_in=3 with in_valid=4'b0011 -> remain in IDLE with in_ready=0. Switching sel_in to 1 -> grant channel 1 on the next edge.
6. Reset mid-packet: assert reset after beat 2 of a 4-beat packet on ch1 -> out_valid=0 next cycle and state IDLE. After release, in mode=1 with only ch1 valid, ch1 is regranted and its stream restarts cleanly.
